// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - memory op codes carried in the EX/MEM slot
//   - LSU state encoding (ISSUE / MERGE)
//   - op classification and alignment-check helpers
package mem_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_MERGE = 1'b1
  } lsu_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic is_subword_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

  // Halfword ops need an even address, word ops a multiple of four.
  // Byte ops and non-memory codes never fault.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = off[0];
      OP_LW, OP_SW:         bad = |off;
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Big-endian lane handling for the load/store unit (purely combinational).
//   i_word      : 32-bit word as read from DataMemory
//   i_offset    : byte offset within the word (addr[1:0])
//   i_op        : memory op code
//   o_data      : selected byte/halfword, sign- or zero-extended; whole word otherwise
//   o_lane_mask : bits of the word covered by the access (all ones for word/other ops)
// The lane mask is what the sub-word store merge uses to splice new data in.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [3:0]  i_op,
  output logic [31:0] o_data,
  output logic [31:0] o_lane_mask
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_byte_mask;
  logic [31:0] w_half_mask;

  // Offset 0 is the most significant byte.
  always_comb begin
    w_byte      = i_word[31:24];
    w_byte_mask = 32'hFF00_0000;
    case (i_offset)
      2'd0: begin w_byte = i_word[31:24]; w_byte_mask = 32'hFF00_0000; end
      2'd1: begin w_byte = i_word[23:16]; w_byte_mask = 32'h00FF_0000; end
      2'd2: begin w_byte = i_word[15:8];  w_byte_mask = 32'h0000_FF00; end
      default: begin w_byte = i_word[7:0]; w_byte_mask = 32'h0000_00FF; end
    endcase
  end

  assign w_half      = i_offset[1] ? i_word[15:0] : i_word[31:16];
  assign w_half_mask = i_offset[1] ? 32'h0000_FFFF : 32'hFFFF_0000;

  always_comb begin
    o_data      = i_word;
    o_lane_mask = 32'hFFFF_FFFF;
    case (i_op)
      OP_LB:  begin o_data = {{24{w_byte[7]}}, w_byte};  o_lane_mask = w_byte_mask; end
      OP_LBU: begin o_data = {24'h0, w_byte};            o_lane_mask = w_byte_mask; end
      OP_SB:  begin                                      o_lane_mask = w_byte_mask; end
      OP_LH:  begin o_data = {{16{w_half[15]}}, w_half}; o_lane_mask = w_half_mask; end
      OP_LHU: begin o_data = {16'h0, w_half};            o_lane_mask = w_half_mask; end
      OP_SH:  begin                                      o_lane_mask = w_half_mask; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit between the EX/MEM boundary and a word-addressed
// DataMemory that only writes whole words.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_*                : EX/MEM slot (valid, op, byte address / ALU result,
//                         store data, rd, reg_write)
//   stall               : hold EX/MEM and earlier stages this cycle
//   mem_*               : DataMemory interface (word index, write data, strobes,
//                         read data); every outgoing mem_* signal is a flop output
//   wb_*                : registered MEM/WB payload, plus misaligned-access flag
//                         and faulting byte address
//
// Handshake: the EX/MEM slot is taken at every rising edge where stall=0; while
// stall=1 the upstream stages must hold in_* unchanged. There is no separate
// ready; stall is the inverse of ready.
//
// Strobes for an instruction are computed from in_* and registered at the same
// edge that captures it into the issue register, so DataMemory sees them during
// the following cycle without any combinational path. Sub-word stores read the
// word in the ISSUE cycle (stall=1), splice the new lane in at the edge, and
// write the merged word during the MERGE cycle.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_misalign,
  output logic [ADDR_W-1:0] wb_bad_addr
);

  lsu_state_e        r_state;

  // Issue register: the instruction whose memory access is in flight.
  logic              r_ir_valid;
  logic [3:0]        r_ir_op;
  logic [ADDR_W-1:0] r_ir_addr;
  logic [15:0]       r_ir_wdata;
  logic [4:0]        r_ir_rd;
  logic              r_ir_reg_write;

  logic              r_stall;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_read;
  logic              r_mem_write;

  logic              r_wb_valid;
  logic [4:0]        r_wb_rd;
  logic              r_wb_reg_write;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_wb_misalign;
  logic [ADDR_W-1:0] r_wb_bad_addr;

  // Decode of the incoming slot (drives the strobe flops).
  logic w_in_go;
  logic w_in_load;
  logic w_in_sw;
  logic w_in_sub;

  assign w_in_go   = in_valid & ~is_misaligned(in_op, in_addr[1:0]);
  assign w_in_load = w_in_go & is_load(in_op);
  assign w_in_sw   = w_in_go & (in_op == OP_SW);
  assign w_in_sub  = w_in_go & is_subword_store(in_op);

  // Decode of the issue register (drives the WB payload).
  logic w_ir_misal;
  logic w_ir_load;
  logic w_ir_store;

  assign w_ir_misal = r_ir_valid & is_misaligned(r_ir_op, r_ir_addr[1:0]);
  assign w_ir_load  = r_ir_valid & is_load(r_ir_op);
  assign w_ir_store = r_ir_valid & is_store(r_ir_op);

  logic [31:0] w_load_data;
  logic [31:0] w_lane_mask;
  logic [31:0] w_store_rep;
  logic [31:0] w_merged;

  lsu_load_align u_align (
    .i_word      (mem_rdata),
    .i_offset    (r_ir_addr[1:0]),
    .i_op        (r_ir_op),
    .o_data      (w_load_data),
    .o_lane_mask (w_lane_mask)
  );

  // Replicate the store data across every lane; the mask picks the right one.
  assign w_store_rep = (r_ir_op == OP_SB) ? {4{r_ir_wdata[7:0]}} : {2{r_ir_wdata}};
  assign w_merged    = (mem_rdata & ~w_lane_mask) | (w_store_rep & w_lane_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_ISSUE;
      r_ir_valid     <= 1'b0;
      r_ir_op        <= OP_NONE;
      r_ir_addr      <= '0;
      r_ir_wdata     <= '0;
      r_ir_rd        <= '0;
      r_ir_reg_write <= 1'b0;
      r_stall        <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
      r_wb_data      <= '0;
      r_wb_misalign  <= 1'b0;
      r_wb_bad_addr  <= '0;
    end else if (r_state == ST_ISSUE && r_stall) begin
      // Sub-word store read phase: capture the merged word, keep the issue
      // register, send a bubble to WB (the store reports at the MERGE edge).
      r_state        <= ST_MERGE;
      r_stall        <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b1;
      r_mem_wdata    <= w_merged;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_misalign  <= 1'b0;
    end else begin
      r_state <= ST_ISSUE;

      // Retire the issue-register instruction into MEM/WB.
      r_wb_valid    <= r_ir_valid;
      r_wb_rd       <= r_ir_rd;
      r_wb_data     <= r_ir_addr;
      r_wb_misalign <= (r_state == ST_ISSUE) && w_ir_misal;
      if (r_state == ST_MERGE) begin
        r_wb_valid     <= 1'b1;
        r_wb_reg_write <= 1'b0;
      end else if (w_ir_misal) begin
        r_wb_reg_write <= 1'b0;
        r_wb_bad_addr  <= r_ir_addr;
      end else if (w_ir_load) begin
        r_wb_reg_write <= r_ir_reg_write;
        r_wb_data      <= w_load_data;
      end else if (w_ir_store) begin
        r_wb_reg_write <= 1'b0;
      end else begin
        r_wb_reg_write <= r_ir_reg_write;
      end

      // Accept the next slot (a bubble when in_valid=0).
      r_ir_valid     <= in_valid;
      r_ir_op        <= in_valid ? in_op : OP_NONE;
      r_ir_addr      <= in_addr;
      r_ir_wdata     <= in_wdata[15:0];
      r_ir_rd        <= in_rd;
      r_ir_reg_write <= in_valid & in_reg_write;
      r_mem_addr     <= {2'b00, in_addr[ADDR_W-1:2]};
      r_mem_read     <= w_in_load | w_in_sub;
      r_mem_write    <= w_in_sw;
      r_stall        <= w_in_sub;
      if (w_in_sw) r_mem_wdata <= in_wdata;
    end
  end

  assign stall        = r_stall;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_data      = r_wb_data;
  assign wb_misalign  = r_wb_misalign;
  assign wb_bad_addr  = r_wb_bad_addr;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage pipeline.
- Sits between the EX/MEM pipeline boundary and the word-addressed DataMemory.
- Converts byte addresses to word indices, handles byte and halfword accesses (sub-word stores by read-modify-write, because DataMemory writes whole words only), and flags misaligned accesses.
- Produces the registered MEM/WB payload consumed by write-back.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data word width; only 32 is supported

Ports:
clk  input  1  pipeline clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  EX/MEM slot holds an instruction
in_op  input  4  memory op code (package constants)
in_addr  input  32  ALU result: byte address for memory ops, result value otherwise
in_wdata  input  32  store data (rt), right-justified
in_rd  input  5  destination register
in_reg_write  input  1  instruction writes the register file
stall  output  1  hold EX/MEM and earlier stages this cycle
mem_addr  output  32  word index to DataMemory, {2'b00, addr[31:2]}
mem_wdata  output  32  word written to DataMemory
mem_read  output  1  DataMemory MemRead
mem_write  output  1  DataMemory MemWrite
mem_rdata  input  32  DataMemory ReadData; undefined (Z) when mem_read=0
wb_valid  output  1  MEM/WB slot valid
wb_rd  output  5  MEM/WB destination register
wb_reg_write  output  1  MEM/WB register-write enable
wb_data  output  32  load result or passed-through ALU result
wb_misalign  output  1  one-cycle misaligned-access exception flag
wb_bad_addr  output  32  faulting byte address, valid when wb_misalign=1

Behaviour:
- Op codes: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8. Codes 9-15 behave as NONE.
- Byte order is big-endian: offset 0 is bits 31:24; halfword offset 0 is bits 31:16.
- All DataMemory-facing outputs come directly from flops. DataMemory is level/event sensitive, so glitches on these outputs are forbidden.
- Issue register (ir_*): loads in_* on every rising edge where stall=0. When in_valid=0 it loads a bubble (valid=0, op=NONE).
- State machine, two states:
  - ISSUE (reset state)
  - MERGE
- ISSUE, per ir op:
  - LW/LH/LHU/LB/LBU aligned: mem_read=1.
  - SW aligned: mem_write=1, mem_wdata=ir_wdata.
  - SB/SH aligned: mem_read=1 and stall=1. At the edge: merge register = mem_rdata with the target byte/halfword replaced by ir_wdata[7:0] / [15:0]; state->MERGE.
- MERGE:
  - mem_write=1, mem_wdata=merge register, mem_read=0, stall=0.
  - Next edge: state->ISSUE.
  - Net cost of a sub-word store: exactly one bubble.
- Alignment: LH/LHU/SH fault when addr[0]=1; LW/SW fault when addr[1:0]!=0; byte ops never fault.
- Faulting op: no memory strobe. Next cycle: wb_misalign=1, wb_bad_addr=addr, wb_reg_write=0, wb_valid=1.
- mem_read and mem_write are never both 1.
- Ops NONE/invalid: no strobes.
- WB registers load at every edge in ISSUE state except the SB/SH read phase (WB gets a bubble then; the store is reported at the MERGE edge).
  - Loads: wb_data = extracted field, sign-extended (LB/LH) or zero-extended (LBU/LHU/LW-as-is).
  - Non-memory ops: wb_data = ir_addr, wb_reg_write = ir_reg_write.
  - Stores: wb_reg_write=0.
- Latency: instruction accepted at edge N; memory access during cycle N..N+1; WB visible after edge N+1. Sub-word stores commit during the MERGE cycle.
- Reset (any time, including mid-MERGE):
  - All flops to 0 and state to ISSUE.
  - stall, mem_read, mem_write, wb_* all drop to 0 immediately.
  - An in-progress sub-word store is abandoned with no write.

Decomposition:
- Shared package mem_pkg: op-code constants, state encoding (ISSUE/MERGE), alignment-check function.
- One sub-module, lsu_load_align: combinational extract plus sign/zero extension from word, offset and op. It is reused by the merge logic for lane selection.

Test Plan:
- Reset low mid-MERGE of SB -> all outputs 0 at once; no mem_write pulse; after release, word at index 4 is unchanged.
- SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> mem_addr=4, mem_write one cycle; next load gives wb_data=0xDEADBEEF, wb_reg_write=1, no stall.
- Word 4 = 0x11223344; SB addr=0x12 data=0xAB -> stall 1 cycle, mem_read then mem_write, word becomes 0x1122AB44; the following instruction is accepted one cycle later.
- Word 4 = 0x80FF7F01; LB 0x10 -> 0xFFFFFF80; LBU 0x10 -> 0x00000080; LH 0x12 -> 0x00007F01; LHU 0x10 -> 0x000080FF.
- LW addr=0x13 -> no strobes; wb_misalign=1 for one cycle; wb_bad_addr=0x13; wb_reg_write=0.
- ALU op in_addr=0x1234, rd=9, reg_write=1, back-to-back with an LW -> wb_data=0x1234 then the load value on consecutive cycles, rd order preserved.
